// File: rtl/oh_edgesched.sv
// oh_edgesched - slow-clock phase scheduler driven by an edge aligner.
//
// Measures the number of fast-clock cycles between firstedge pulses, declares
// lock after LOCKCNT consecutive equal periods, and while locked issues a
// one-cycle strobe at a programmed position within every slow period.
//
// Parameters:
//   CW       width of period counter, ratio and phase (max ratio 2^CW-1)
//   LOCKCNT  consecutive equal periods needed to lock (>=1)
//
// Ports:
//   clk        fast clock, all logic on posedge
//   reset      asynchronous active-high reset
//   en         enable; low returns to IDLE and clears statistics
//   firstedge  one-cycle pulse per slow-clock rising edge
//   phase      strobe position 1..ratio
//   ratio      last locked period in clk cycles
//   locked     period stable, strobe active
//   strobe     phase strobe (state==LOCK && cnt==phase)
//   lockerr    one-cycle pulse on loss of lock
//   errcnt     lock-loss count
//
// Build option: define OH_EDGESCHED_ERRCNT_EN to implement the saturating
// lock-loss counter; otherwise errcnt is tied to zero.

module oh_edgesched #(
    parameter int unsigned CW      = 8,
    parameter int unsigned LOCKCNT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          firstedge,
    input  logic [CW-1:0] phase,
    output logic [CW-1:0] ratio,
    output logic          locked,
    output logic          strobe,
    output logic          lockerr,
    output logic [7:0]    errcnt
);

    localparam int unsigned MW = (LOCKCNT > 1) ? $clog2(LOCKCNT) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, MEAS, TRACK, LOCK} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] per_q, per_d;
    logic [CW-1:0] ratio_q, ratio_d;
    logic [MW-1:0] match_q, match_d;
    logic          locked_q, locked_d;
    logic          lockerr_q, lockerr_d;
    logic          cnt_sat;
    logic          per_match;
    logic          err;

    assign cnt_sat   = (cnt_q == '1);
    // A period shorter than 2 cycles never counts as a match.
    assign per_match = firstedge && (cnt_q == per_q) && (cnt_q > CW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = firstedge ? CW'(1) : (cnt_sat ? cnt_q : cnt_q + 1'b1);
        per_d   = per_q;
        match_d = match_q;
        ratio_d = ratio_q;
        err     = 1'b0;

        if (!en) begin
            state_d = IDLE;
            per_d   = '0;
            match_d = '0;
        end else begin
            case (state_q)
                IDLE:  state_d = WAIT;
                WAIT:  if (firstedge) state_d = MEAS;
                MEAS: begin
                    if (firstedge) begin
                        per_d   = cnt_q;
                        match_d = '0;
                        state_d = TRACK;
                    end else if (cnt_sat) begin
                        state_d = WAIT;
                    end
                end
                TRACK: begin
                    if (firstedge) begin
                        if (per_match) begin
                            if (match_q == MW'(LOCKCNT - 1)) begin
                                state_d = LOCK;
                                ratio_d = per_q;
                            end else begin
                                match_d = match_q + 1'b1;
                            end
                        end else begin
                            per_d   = cnt_q;
                            match_d = '0;
                        end
                    end else if ((cnt_q > per_q) || cnt_sat) begin
                        // Saturated counter also covers per==2^CW-1, where
                        // cnt can never exceed per.
                        state_d = MEAS;
                    end
                end
                LOCK: begin
                    if (firstedge) begin
                        if (!per_match) begin
                            err     = 1'b1;
                            per_d   = cnt_q;
                            match_d = '0;
                            state_d = TRACK;
                        end
                    end else if (cnt_q == per_q) begin
                        err     = 1'b1;
                        state_d = MEAS;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        locked_d  = (state_d == LOCK);
        lockerr_d = err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            match_q   <= '0;
            ratio_q   <= '0;
            locked_q  <= 1'b0;
            lockerr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            match_q   <= match_d;
            ratio_q   <= ratio_d;
            locked_q  <= locked_d;
            lockerr_q <= lockerr_d;
        end
    end

`ifdef OH_EDGESCHED_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (!en) begin
            errcnt_d = '0;
        end else if (err && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign errcnt = errcnt_q;
`else
    assign errcnt = 8'h0;
`endif

    assign ratio   = ratio_q;
    assign locked  = locked_q;
    assign lockerr = lockerr_q;
    assign strobe  = (state_q == LOCK) && (cnt_q == phase);

endmodule
